// File: rtl/linear_cfg_loader_if.sv
// Parameter word stream feeding the linear-layer config loader.
// The DMA side uses master and the loader uses slave.
interface linear_cfg_loader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/linear_cfg_loader.sv
// Streams weight/bias words into a linear layer's config port.
// Inference traffic to the layer is held off while a load is active.
module linear_cfg_loader #(
    parameter  int unsigned IN_DIM  = 8,
    parameter  int unsigned OUT_DIM = 8,
    parameter  int unsigned DATA_W  = 16,
    localparam int unsigned WCOUNT  = IN_DIM * OUT_DIM,
    localparam int unsigned TOTAL   = WCOUNT + OUT_DIM,
    localparam int unsigned ADDR_W  = $clog2(TOTAL),
    localparam int unsigned LEN_W   = ADDR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]    load_len,
    input  logic                abort,
    linear_cfg_loader_if.slave  strm,
    output logic                cfg_we,
    output logic [ADDR_W-1:0]   cfg_addr,
    output logic [DATA_W-1:0]   cfg_wdata,
    input  logic                inf_valid,
    output logic                inf_ready,
    output logic                lin_valid_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                weights_valid
);

    localparam int unsigned SUM_W = ADDR_W + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              we_d, done_d, err_d, wv_d;
    logic [ADDR_W-1:0] caddr_d;
    logic [DATA_W-1:0] cdata_d;
    logic [SUM_W-1:0]  end_sum;
    logic              bad_req;

    // Range check is done one bit wider than the length so it cannot overflow
    assign end_sum = SUM_W'(start_addr) + SUM_W'(load_len);
    assign bad_req = (load_len == '0) || (end_sum > SUM_W'(TOTAL));

    assign busy         = (state_q != IDLE);
    assign inf_ready    = !busy;
    assign lin_valid_in = inf_valid & !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            cfg_we        <= 1'b0;
            cfg_addr      <= '0;
            cfg_wdata     <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            weights_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            cfg_we        <= we_d;
            cfg_addr      <= caddr_d;
            cfg_wdata     <= cdata_d;
            done          <= done_d;
            err           <= err_d;
            weights_valid <= wv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        we_d         = 1'b0;
        caddr_d      = cfg_addr;
        cdata_d      = cfg_wdata;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wv_d         = weights_valid;
        strm.s_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        addr_d  = start_addr;
                        rem_d   = load_len;
                    end
                end
            end
            LOAD: begin
                // Abort drops ready so the word on the bus in this cycle is not consumed
                strm.s_ready = !abort;
                if (abort) begin
                    state_d = IDLE;
                    wv_d    = 1'b0;
                end else if (strm.s_valid) begin
                    we_d    = 1'b1;
                    caddr_d = addr_q;
                    cdata_d = strm.s_data;
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                if (abort) begin
                    wv_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    wv_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_linear_cfg_loader.sv
// Directed bench for linear_cfg_loader with a 2x2 layer (TOTAL = 6).
// Expected values are hand-derived cycle by cycle.
module tb_linear_cfg_loader;

    localparam int unsigned IN_DIM  = 2;
    localparam int unsigned OUT_DIM = 2;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned LEN_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  load_len;
    logic              abort;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              inf_valid;
    logic              inf_ready;
    logic              lin_valid_in;
    logic              busy;
    logic              done;
    logic              err;
    logic              weights_valid;

    int n_chk = 0;
    int n_err = 0;

    linear_cfg_loader_if #(.DATA_W(DATA_W)) strm ();

    linear_cfg_loader #(
        .IN_DIM (IN_DIM),
        .OUT_DIM(OUT_DIM),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .load_len     (load_len),
        .abort        (abort),
        .strm         (strm),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .inf_valid    (inf_valid),
        .inf_ready    (inf_ready),
        .lin_valid_in (lin_valid_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .weights_valid(weights_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        start      = 1'b1;
        start_addr = a;
        load_len   = l;
        tick();
        start      = 1'b0;
    endtask

    // One accepted word: write must appear on the following edge
    task automatic feed(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] exp_a, input string tag);
        strm.s_valid = 1'b1;
        strm.s_data  = d;
        tick();
        check({tag, "_we"},   32'(cfg_we),    32'd1);
        check({tag, "_addr"}, 32'(cfg_addr),  32'(exp_a));
        check({tag, "_data"}, 32'(cfg_wdata), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        start_addr   = '0;
        load_len     = '0;
        abort        = 1'b0;
        inf_valid    = 1'b0;
        strm.s_valid = 1'b0;
        strm.s_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_we",    32'(cfg_we),        32'd0);
        check("rst_addr",  32'(cfg_addr),      32'd0);
        check("rst_data",  32'(cfg_wdata),     32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_done",  32'(done),          32'd0);
        check("rst_err",   32'(err),           32'd0);
        check("rst_wv",    32'(weights_valid), 32'd0);
        check("rst_ready", 32'(strm.s_ready),  32'd0);

        // Full back-to-back load with inference valid held high
        inf_valid = 1'b1;
        #1;
        check("t1_idle_infr", 32'(inf_ready),    32'd1);
        check("t1_idle_lin",  32'(lin_valid_in), 32'd1);
        do_start(3'd0, 4'd6);
        check("t1_busy",  32'(busy),          32'd1);
        check("t1_infr",  32'(inf_ready),     32'd0);
        check("t1_lin",   32'(lin_valid_in),  32'd0);
        check("t1_ready", 32'(strm.s_ready),  32'd1);
        for (int i = 0; i < 6; i++) begin
            feed(DATA_W'(10 + i), ADDR_W'(i), "t1_w");
            check("t1_w_lin", 32'(lin_valid_in), 32'd0);
        end
        strm.s_valid = 1'b0;
        #1;
        check("t1_flush_busy",  32'(busy),         32'd1);
        check("t1_flush_ready", 32'(strm.s_ready), 32'd0);
        check("t1_flush_done",  32'(done),         32'd0);
        tick();
        check("t1_done",  32'(done),          32'd1);
        check("t1_wv",    32'(weights_valid), 32'd1);
        check("t1_idle",  32'(busy),          32'd0);
        check("t1_we0",   32'(cfg_we),        32'd0);
        check("t1_infr1", 32'(inf_ready),     32'd1);
        check("t1_lin1",  32'(lin_valid_in),  32'd1);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        inf_valid = 1'b0;

        // Load of the last two biases with a stalled stream cycle
        do_start(3'd4, 4'd2);
        feed(16'h0100, 3'd4, "t2_a");
        strm.s_valid = 1'b0;
        tick();
        check("t2_stall_we",   32'(cfg_we),   32'd0);
        check("t2_stall_addr", 32'(cfg_addr), 32'd4);
        feed(16'h0101, 3'd5, "t2_b");
        strm.s_valid = 1'b0;
        tick();
        check("t2_done", 32'(done), 32'd1);
        check("t2_wv",   32'(weights_valid), 32'd1);

        // Rejected requests
        do_start(3'd5, 4'd2);
        check("t3_err_a",  32'(err),    32'd1);
        check("t3_busy_a", 32'(busy),   32'd0);
        check("t3_we_a",   32'(cfg_we), 32'd0);
        tick();
        check("t3_err_pulse", 32'(err), 32'd0);
        do_start(3'd1, 4'd0);
        check("t3_err_b",  32'(err),  32'd1);
        check("t3_busy_b", 32'(busy), 32'd0);
        do_start(3'd0, 4'd7);
        check("t3_err_c",  32'(err),  32'd1);
        // A load ending exactly on the last address is legal
        do_start(3'd5, 4'd1);
        check("t3_edge_err",  32'(err),  32'd0);
        check("t3_edge_busy", 32'(busy), 32'd1);
        feed(16'hFFFF, 3'd5, "t3_edge");
        strm.s_valid = 1'b0;
        tick();
        check("t3_edge_done", 32'(done), 32'd1);

        // Reset in the middle of a load, then a clean reload
        do_start(3'd0, 4'd6);
        feed(16'd20, 3'd0, "t6_a");
        feed(16'd21, 3'd1, "t6_b");
        strm.s_data = 16'd22;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_we",   32'(cfg_we),        32'd0);
        check("t6_addr", 32'(cfg_addr),      32'd0);
        check("t6_data", 32'(cfg_wdata),     32'd0);
        check("t6_busy", 32'(busy),          32'd0);
        check("t6_wv",   32'(weights_valid), 32'd0);
        check("t6_rdy",  32'(strm.s_ready),  32'd0);
        strm.s_valid = 1'b0;
        do_start(3'd2, 4'd2);
        feed(16'd30, 3'd2, "t6_c");
        feed(16'd31, 3'd3, "t6_d");
        strm.s_valid = 1'b0;
        tick();
        check("t6_done", 32'(done),          32'd1);
        check("t6_wv1",  32'(weights_valid), 32'd1);

        // Abort after three words; a start while busy must be ignored
        do_start(3'd0, 4'd6);
        feed(16'd40, 3'd0, "t4_a");
        start      = 1'b1;
        start_addr = 3'd3;
        load_len   = 4'd1;
        feed(16'd41, 3'd1, "t4_b");
        start = 1'b0;
        check("t4_no_err", 32'(err), 32'd0);
        feed(16'd42, 3'd2, "t4_c");
        strm.s_data = 16'd43;
        abort = 1'b1;
        #1;
        check("t4_abort_ready", 32'(strm.s_ready), 32'd0);
        tick();
        abort        = 1'b0;
        strm.s_valid = 1'b0;
        check("t4_we",   32'(cfg_we),        32'd0);
        check("t4_busy", 32'(busy),          32'd0);
        check("t4_done", 32'(done),          32'd0);
        check("t4_wv",   32'(weights_valid), 32'd0);
        tick();
        check("t4_we_after",   32'(cfg_we), 32'd0);
        check("t4_done_after", 32'(done),   32'd0);

        // Abort in idle has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_err",  32'(err),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
